// File: rtl/mii_frame_sink.sv
`default_nettype none
// mii_frame_sink: MII transmit-side frame checker. It strips the preamble and SFD,
// rebuilds bytes, checks FCS/alignment/length and keeps saturating good/bad counters.
module mii_frame_sink #(
  parameter int MAX_BYTES = 1518,
  parameter int MIN_BYTES = 64
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        mii_en,
  input  logic        mii_er,
  input  logic [3:0]  mii_data,
  output logic [7:0]  byte_data,
  output logic        byte_valid,
  output logic        byte_sof,
  output logic        frame_done,
  output logic        frame_good,
  output logic [10:0] frame_len,
  output logic [3:0]  frame_err,
  output logic [15:0] good_cnt,
  output logic [15:0] bad_cnt
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREAMBLE = 2'd1,
    DATA     = 2'd2,
    DROP     = 2'd3
  } state_t;

  localparam logic [10:0] MAX_LEN     = 11'(MAX_BYTES);
  localparam logic [10:0] MIN_LEN     = 11'(MIN_BYTES);
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

  state_t      state_q, state_d;
  logic        phase_q, phase_d;
  logic [3:0]  low_q, low_d;
  logic [31:0] crc_q, crc_d;
  logic [10:0] len_q, len_d;
  logic        sym_err_q, sym_err_d;
  logic [7:0]  bdata_q, bdata_d;
  logic        bvalid_q, bvalid_d;
  logic        bsof_q, bsof_d;
  logic        done_q, done_d;
  logic        good_q, good_d;
  logic [10:0] flen_q, flen_d;
  logic [3:0]  ferr_q, ferr_d;
  logic [15:0] good_cnt_q, good_cnt_d;
  logic [15:0] bad_cnt_q, bad_cnt_d;

  function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] b);
    logic [31:0] c;
    c = crc ^ {24'd0, b};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    low_d      = low_q;
    crc_d      = crc_q;
    len_d      = len_q;
    sym_err_d  = sym_err_q;
    bdata_d    = bdata_q;
    bvalid_d   = 1'b0;
    bsof_d     = 1'b0;
    done_d     = 1'b0;
    good_d     = good_q;
    flen_d     = flen_q;
    ferr_d     = ferr_q;
    good_cnt_d = good_cnt_q;
    bad_cnt_d  = bad_cnt_q;

    // Counters follow the status strobe by one cycle.
    if (done_q) begin
      if (good_q) begin
        if (good_cnt_q != 16'hFFFF) good_cnt_d = good_cnt_q + 16'd1;
      end else begin
        if (bad_cnt_q != 16'hFFFF) bad_cnt_d = bad_cnt_q + 16'd1;
      end
    end

    case (state_q)
      IDLE: begin
        if (mii_en) begin
          state_d = (mii_data == 4'h5) ? PREAMBLE : DROP;
        end
      end
      PREAMBLE: begin
        if (!mii_en) begin
          state_d = IDLE;
        end else if (mii_data == 4'hD) begin
          state_d   = DATA;
          len_d     = 11'd0;
          crc_d     = 32'hFFFFFFFF;
          phase_d   = 1'b0;
          sym_err_d = 1'b0;
        end else if (mii_data != 4'h5) begin
          state_d = DROP;
        end
      end
      DATA: begin
        if (!mii_en) begin
          state_d = IDLE;
          done_d  = 1'b1;
          flen_d  = len_q;
          ferr_d  = {sym_err_q, (len_q < MIN_LEN) || (len_q > MAX_LEN),
                     phase_q, crc_q != CRC_RESIDUE};
          good_d  = (ferr_d == 4'd0);
        end else begin
          if (mii_er) sym_err_d = 1'b1;
          if (!phase_q) begin
            low_d   = mii_data;
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            crc_d   = crc_byte(crc_q, {mii_data, low_q});
            if (len_q != 11'h7FF) len_d = len_q + 11'd1;
            // Oversize frames are still counted and checked, but only the legal prefix is streamed.
            if (len_q < MAX_LEN) begin
              bvalid_d = 1'b1;
              bsof_d   = (len_q == 11'd0);
              bdata_d  = {mii_data, low_q};
            end
          end
        end
      end
      DROP: begin
        if (!mii_en) begin
          state_d = IDLE;
          done_d  = 1'b1;
          flen_d  = 11'd0;
          ferr_d  = 4'b1000;
          good_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= IDLE;
      phase_q    <= 1'b0;
      low_q      <= 4'd0;
      crc_q      <= 32'hFFFFFFFF;
      len_q      <= 11'd0;
      sym_err_q  <= 1'b0;
      bdata_q    <= 8'd0;
      bvalid_q   <= 1'b0;
      bsof_q     <= 1'b0;
      done_q     <= 1'b0;
      good_q     <= 1'b0;
      flen_q     <= 11'd0;
      ferr_q     <= 4'd0;
      good_cnt_q <= 16'd0;
      bad_cnt_q  <= 16'd0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      low_q      <= low_d;
      crc_q      <= crc_d;
      len_q      <= len_d;
      sym_err_q  <= sym_err_d;
      bdata_q    <= bdata_d;
      bvalid_q   <= bvalid_d;
      bsof_q     <= bsof_d;
      done_q     <= done_d;
      good_q     <= good_d;
      flen_q     <= flen_d;
      ferr_q     <= ferr_d;
      good_cnt_q <= good_cnt_d;
      bad_cnt_q  <= bad_cnt_d;
    end
  end

  assign byte_data  = bdata_q;
  assign byte_valid = bvalid_q;
  assign byte_sof   = bsof_q;
  assign frame_done = done_q;
  assign frame_good = good_q;
  assign frame_len  = flen_q;
  assign frame_err  = ferr_q;
  assign good_cnt   = good_cnt_q;
  assign bad_cnt    = bad_cnt_q;

endmodule
`default_nettype wire
